md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide sequencer that sits beside the ALU in the EX stage and owns the HI/LO register pair. It accepts one operation per start pulse and holds `busy` for a fixed, parameterised number of cycles. It then commits the result to HI/LO. It also generates the stall request that the hazard unit uses to freeze D/F while HI/LO are not yet valid.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal values are 1 or greater.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal values are 1 or greater.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX-stage pulse: the instruction in EX is an md operation.
- `mdop`  in  3  operation code: 0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo; 6 and 7 are no-ops.
- `A`  in  32  operand rs: multiplicand/dividend; also the data source for mthi/mtlo.
- `B`  in  32  operand rt: multiplier/divisor.
- `md_req`  in  1  D-stage instruction is md-class (mult*, div*, mthi, mtlo, mfhi, mflo).
- `busy`  out  1  operation in flight.
- `stall`  out  1  combinational: `md_req & (busy | start)`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- The block has two states: IDLE and RUN. It has a down-counter `cnt` of width sufficient for max(MULT_CYCLES, DIV_CYCLES), plus `res_hi` and `res_lo` result holding registers.
- IDLE with `start` = 1 and mdop in 0–3:
  - Compute the result from A and B and latch it into `res_hi`/`res_lo`.
  - Load `cnt` with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - Go to RUN and set `busy` = 1.
- IDLE with `start` = 1 and mdop 4 or 5: write A into `hi` (4) or `lo` (5) at that edge. `busy` stays 0 and the state stays IDLE.
- IDLE with `start` = 1 and mdop 6 or 7: no state change.
- RUN:
  - `cnt` decrements each edge.
  - On the edge where `cnt` == 1, `hi`/`lo` take `res_hi`/`res_lo`, `busy` returns to 0 and the state returns to IDLE.
- `start` while in RUN is ignored; no operand is latched. The hazard unit guarantees this does not happen, and the bench checks that it is dropped.
- Arithmetic rules:
  - mult: `{hi, lo}` = signed(A) × signed(B), full 64-bit product.
  - multu: `{hi, lo}` = unsigned A × B, 64-bit.
  - div: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - div with A = 0x80000000 and B = 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned quotient in lo, unsigned remainder in hi.
  - Divide by zero (div or divu, B = 0): the full DIV_CYCLES busy period still runs, and HI/LO are left unchanged at commit.
- Reset (`reset` = 0, at any time including mid-RUN): the operation is aborted immediately, with no commit.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, state = IDLE, `cnt` = 0, `res_hi` = `res_lo` = 0. `stall` then equals `md_req & start`.
- Operation sequence, with `start` sampled at edge E0:
  - `busy` rises after E0.
  - `busy` stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - `hi`/`lo` update and `busy` falls at edge E0+N.
  - An mfhi/mflo in D therefore stalls for the cycle of `start` plus N busy cycles, and reads the new value at E0+N+1.
- mthi/mtlo latency: `hi`/`lo` are updated at E0 itself, and are visible in the following cycle. There is no busy period.
- Back-to-back operation: a new `start` is accepted in the first IDLE cycle after `busy` falls. No dead cycle is required.
- `stall` is purely combinational and has no registered delay.
- Reset release: the first rising edge after `reset` returns to 1 may accept `start`.

## Test plan
- multu A = 0xFFFFFFFF, B = 0x00000002, MULT_CYCLES = 5 -> `busy` = 1 for exactly 5 cycles; then hi = 0x00000001, lo = 0xFFFFFFFE. HI/LO keep their old values during busy.
- mult A = 0xFFFFFFFD (−3), B = 4 -> after 5 cycles, hi = 0xFFFFFFFF, lo = 0xFFFFFFF4.
- div A = 0xFFFFFFF9 (−7), B = 2, DIV_CYCLES = 10 -> after 10 cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- div A = 0x80000000, B = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- divu with B = 0 and prior hi = 0x11, lo = 0x22 -> busy for 10 cycles; hi/lo remain 0x11 and 0x22.
- mthi A = 0xDEADBEEF, then `start` (mult) issued again while busy, with `md_req` = 1 -> hi = 0xDEADBEEF next cycle. The second start is ignored, and `stall` = 1 through the whole busy window.
- div in flight with `reset` pulled low at cycle 4 -> busy = 0 and hi = lo = 0 immediately. After reset is released there is no commit, and a new multu completes normally.

Source files
------------

// File: rtl/md_unit_if.sv
// Operand, control and result bundle between the EX stage and md_unit.
// The hazard unit also reads stall from here.
interface md_unit_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, A, B, md_req,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, mdop, A, B, md_req,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// The result is computed at start, then held in res_hi/res_lo until the busy count expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    md_unit_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   res_hi, res_hi_nx;
    logic [31:0]   res_lo, res_lo_nx;
    logic [31:0]   hi_q, hi_nx;
    logic [31:0]   lo_q, lo_nx;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_div, bu_div;
    logic [31:0] uq, ur, sq, sr, dq, dr;
    logic        b_zero;

    always_comb begin
        prod_s = $signed(md.A) * $signed(md.B);
        prod_u = {32'd0, md.A} * {32'd0, md.B};
    end

    // Signed divide on magnitudes so that 0x80000000 / -1 wraps to itself
    // and never depends on simulator overflow behaviour.
    always_comb begin
        b_zero = (md.B == 32'd0);
        a_mag  = md.A[31] ? (32'd0 - md.A) : md.A;
        b_mag  = md.B[31] ? (32'd0 - md.B) : md.B;
        b_div  = b_zero ? 32'd1 : b_mag;
        bu_div = b_zero ? 32'd1 : md.B;
        uq     = a_mag / b_div;
        ur     = a_mag % b_div;
        sq     = (md.A[31] ^ md.B[31]) ? (32'd0 - uq) : uq;
        sr     = md.A[31] ? (32'd0 - ur) : ur;
        dq     = md.A / bu_div;
        dr     = md.A % bu_div;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            res_hi <= res_hi_nx;
            res_lo <= res_lo_nx;
            hi_q   <= hi_nx;
            lo_q   <= lo_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        res_hi_nx = res_hi;
        res_lo_nx = res_lo;
        hi_nx     = hi_q;
        lo_nx     = lo_q;
        unique case (state)
            IDLE: begin
                if (md.start) begin
                    case (md.mdop)
                        3'd0: begin
                            {res_hi_nx, res_lo_nx} = prod_s;
                            cnt_nx   = CW'(MULT_CYCLES);
                            state_nx = RUN;
                        end
                        3'd1: begin
                            {res_hi_nx, res_lo_nx} = prod_u;
                            cnt_nx   = CW'(MULT_CYCLES);
                            state_nx = RUN;
                        end
                        3'd2, 3'd3: begin
                            // Divide by zero commits the current HI/LO back,
                            // which is safe because nothing can write them in RUN.
                            if (b_zero) begin
                                res_hi_nx = hi_q;
                                res_lo_nx = lo_q;
                            end else if (md.mdop == 3'd2) begin
                                res_hi_nx = sr;
                                res_lo_nx = sq;
                            end else begin
                                res_hi_nx = dr;
                                res_lo_nx = dq;
                            end
                            cnt_nx   = CW'(DIV_CYCLES);
                            state_nx = RUN;
                        end
                        3'd4: hi_nx = md.A;
                        3'd5: lo_nx = md.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    hi_nx    = res_hi;
                    lo_nx    = res_lo;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        md.busy  = (state == RUN);
        md.stall = md.md_req & (md.busy | md.start);
        md.hi    = hi_q;
        md.lo    = lo_q;
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with default cycle counts (5 mult, 10 div).
// Every expected value is hand computed.
module tb_md_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    md_unit_if md();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n, output bit held);
        logic [31:0] oh, ol;
        oh = md.hi;
        ol = md.lo;
        md.start = 1'b1;
        md.mdop  = op;
        md.A     = a;
        md.B     = b;
        step();
        md.start = 1'b0;
        n    = 0;
        held = 1'b1;
        while (md.busy && n < 100) begin
            if (md.hi !== oh || md.lo !== ol) held = 1'b0;
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        md.start  = 1'b0;
        md.mdop   = 3'd0;
        md.A      = '0;
        md.B      = '0;
        md.md_req = 1'b0;
        step();
        step();
        checks++;
        if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h want 0/0/0",
                     md.busy, md.hi, md.lo);
        end
        md.md_req = 1'b1;
        #1;
        checks++;
        if (md.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_idle: got %b want 0", md.stall);
        end
        md.start = 1'b1;
        #1;
        checks++;
        if (md.stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_start: got %b want 1", md.stall);
        end
        md.start  = 1'b0;
        md.md_req = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_multu();
        int n;
        bit held;
        do_op(3'd1, 32'hFFFFFFFF, 32'h2, n, held);
        checks++;
        if (n != 5 || !held) begin
            errors++;
            $display("FAIL multu_busy: cycles=%0d held=%b want 5/1", n, held);
        end
        checks++;
        if (md.hi !== 32'h1 || md.lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL multu_result: hi=%h lo=%h want 00000001/fffffffe",
                     md.hi, md.lo);
        end
    endtask

    task automatic test_mult();
        int n;
        bit held;
        do_op(3'd0, 32'hFFFFFFFD, 32'h4, n, held);
        checks++;
        if (n != 5 || md.hi !== 32'hFFFFFFFF || md.lo !== 32'hFFFFFFF4) begin
            errors++;
            $display("FAIL mult_neg: n=%0d hi=%h lo=%h want 5 ffffffff/fffffff4",
                     n, md.hi, md.lo);
        end
    endtask

    task automatic test_div();
        int n;
        bit held;
        do_op(3'd2, 32'hFFFFFFF9, 32'h2, n, held);
        checks++;
        if (n != 10 || !held) begin
            errors++;
            $display("FAIL div_busy: cycles=%0d held=%b want 10/1", n, held);
        end
        checks++;
        if (md.hi !== 32'hFFFFFFFF || md.lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg: hi=%h lo=%h want ffffffff/fffffffd",
                     md.hi, md.lo);
        end
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n, held);
        checks++;
        if (md.hi !== 32'h0 || md.lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_ovf: hi=%h lo=%h want 00000000/80000000",
                     md.hi, md.lo);
        end
        do_op(3'd3, 32'd100, 32'd7, n, held);
        checks++;
        if (n != 10 || md.hi !== 32'd2 || md.lo !== 32'd14) begin
            errors++;
            $display("FAIL divu: n=%0d hi=%h lo=%h want 10 2/e", n, md.hi, md.lo);
        end
    endtask

    task automatic test_div_zero();
        int n;
        bit held;
        md.start = 1'b1;
        md.mdop  = 3'd4;
        md.A     = 32'h11;
        step();
        md.mdop  = 3'd5;
        md.A     = 32'h22;
        step();
        md.start = 1'b0;
        checks++;
        if (md.hi !== 32'h11 || md.lo !== 32'h22 || md.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b want 11/22/0",
                     md.hi, md.lo, md.busy);
        end
        do_op(3'd3, 32'h1234, 32'h0, n, held);
        checks++;
        if (n != 10 || md.hi !== 32'h11 || md.lo !== 32'h22) begin
            errors++;
            $display("FAIL divu_zero: n=%0d hi=%h lo=%h want 10 11/22",
                     n, md.hi, md.lo);
        end
        do_op(3'd2, 32'hFFFFFFFF, 32'h0, n, held);
        checks++;
        if (n != 10 || md.hi !== 32'h11 || md.lo !== 32'h22) begin
            errors++;
            $display("FAIL div_zero: n=%0d hi=%h lo=%h want 10 11/22",
                     n, md.hi, md.lo);
        end
    endtask

    task automatic test_noop();
        md.start = 1'b1;
        md.mdop  = 3'd6;
        md.A     = 32'hAAAA5555;
        step();
        md.mdop  = 3'd7;
        step();
        md.start = 1'b0;
        checks++;
        if (md.busy !== 1'b0 || md.hi !== 32'h11 || md.lo !== 32'h22) begin
            errors++;
            $display("FAIL noop: busy=%b hi=%h lo=%h want 0 11/22",
                     md.busy, md.hi, md.lo);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        bit stall_ok;
        md.md_req = 1'b1;
        md.start  = 1'b1;
        md.mdop   = 3'd4;
        md.A      = 32'hDEADBEEF;
        step();
        checks++;
        if (md.hi !== 32'hDEADBEEF || md.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b want deadbeef/0", md.hi, md.busy);
        end
        md.mdop = 3'd0;
        md.A    = 32'd3;
        md.B    = 32'd5;
        #1;
        stall_ok = (md.stall === 1'b1);
        step();
        md.start = 1'b0;
        n = 0;
        while (md.busy && n < 100) begin
            if (md.stall !== 1'b1) stall_ok = 1'b0;
            md.start = (n == 1);
            md.mdop  = 3'd0;
            md.A     = 32'd7;
            md.B     = 32'd7;
            #1;
            if (md.stall !== 1'b1) stall_ok = 1'b0;
            step();
            n++;
        end
        md.start = 1'b0;
        #1;
        checks++;
        if (!stall_ok || md.stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_window: ok=%b after=%b want 1/0",
                     stall_ok, md.stall);
        end
        checks++;
        if (n != 5 || md.hi !== 32'd0 || md.lo !== 32'd15) begin
            errors++;
            $display("FAIL start_in_run: n=%0d hi=%h lo=%h want 5 0/f",
                     n, md.hi, md.lo);
        end
        step();
        checks++;
        if (md.busy !== 1'b0 || md.lo !== 32'd15) begin
            errors++;
            $display("FAIL dropped_start: busy=%b lo=%h want 0/f", md.busy, md.lo);
        end
        md.md_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        bit h;
        do_op(3'd1, 32'd2, 32'd3, n1, h);
        checks++;
        if (n1 != 5 || md.hi !== 32'd0 || md.lo !== 32'd6) begin
            errors++;
            $display("FAIL b2b_first: n=%0d hi=%h lo=%h want 5 0/6",
                     n1, md.hi, md.lo);
        end
        do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, n2, h);
        checks++;
        if (n2 != 5 || md.hi !== 32'd0 || md.lo !== 32'd1) begin
            errors++;
            $display("FAIL b2b_second: n=%0d hi=%h lo=%h want 5 0/1",
                     n2, md.hi, md.lo);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit h;
        bit quiet;
        md.start = 1'b1;
        md.mdop  = 3'd4;
        md.A     = 32'h55;
        step();
        md.mdop  = 3'd2;
        md.A     = 32'd100;
        md.B     = 32'd7;
        step();
        md.start = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h want 0 0/0",
                     md.busy, md.hi, md.lo);
        end
        step();
        reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0)
                quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL no_commit: busy=%b hi=%h lo=%h want 0 0/0",
                     md.busy, md.hi, md.lo);
        end
        do_op(3'd1, 32'd6, 32'd7, n, h);
        checks++;
        if (n != 5 || md.hi !== 32'd0 || md.lo !== 32'd42) begin
            errors++;
            $display("FAIL post_reset_multu: n=%0d hi=%h lo=%h want 5 0/2a",
                     n, md.hi, md.lo);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_noop();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
